// File: rtl/crc16_pkg.sv
// Shared types and constants for the CRC-16 word engine: tap masks and default INIT/XOROUT.
package crc16_pkg;

  typedef logic [15:0] crc16_t;

  localparam crc16_t CRC16_INIT_DEFAULT   = 16'h0000;
  localparam crc16_t CRC16_XOROUT_DEFAULT = 16'h0000;

  // Mask i has bit j set iff T[j] feeds next-state bit i.
  localparam crc16_t TAPS [16] = '{
    16'h27CD, 16'h6857, 16'hD0AE, 16'h8691,
    16'h2AEF, 16'h55DE, 16'h8C71, 16'h18E2,
    16'h1609, 16'h2C12, 16'h7FE9, 16'hFFD2,
    16'hD869, 16'h971F, 16'h09F3, 16'h13E6
  };

endpackage

// File: rtl/crc16_next_comb.sv
// Purely combinational CRC-16 next-state network: next[i] = XOR of (state ^ data) under TAPS[i].
import crc16_pkg::*;

module crc16_next_comb (
  input  crc16_t state,
  input  crc16_t data,
  output crc16_t next
);

  crc16_t t;

  assign t = state ^ data;

  always_comb begin
    // NOTE: every bit of next is assigned on every pass, so no latch can be inferred.
    next = '0;
    for (int i = 0; i < 16; i++) begin
      next[i] = ^(t & TAPS[i]);
    end
  end

endmodule

// File: rtl/crc16_word_engine.sv
// Clocked CRC-16 word accumulator with synchronous clear and a valid strobe.
// Optional output mask enabled by defining CRC16_XOROUT_EN.
import crc16_pkg::*;

module crc16_word_engine #(
  parameter crc16_t INIT   = CRC16_INIT_DEFAULT,
  parameter crc16_t XOROUT = CRC16_XOROUT_DEFAULT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   data_valid,
  input  crc16_t data,
  output crc16_t crc_out,
  output logic   crc_valid
);

  crc16_t state_q, state_d;
  crc16_t next_state;
  logic   valid_q, valid_d;

  crc16_next_comb u_next (
    .state (state_q),
    .data  (data),
    .next  (next_state)
  );

  // Clear wins over a coincident word; the word is dropped, not deferred.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    if (clear) begin
      state_d = INIT;
    end else if (data_valid) begin
      state_d = next_state;
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset covers every register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

`ifdef CRC16_XOROUT_EN
  assign crc_out = state_q ^ XOROUT;
`else
  // XOROUT has no effect in this build.
  logic unused_xorout;
  assign unused_xorout = ^XOROUT;
  assign crc_out       = state_q;
`endif

  assign crc_valid = valid_q;

endmodule

// File: tb/tb_crc16_word_engine.sv
// Self-checking bench for crc16_word_engine: directed vectors plus random traffic against a
// column-superposition reference model built from the tap sets.
module tb_crc16_word_engine;

  localparam logic [15:0] INIT   = 16'h0000;
  localparam logic [15:0] XOROUT = 16'hFFFF;
`ifdef CRC16_XOROUT_EN
  localparam logic [15:0] XM = XOROUT;
`else
  localparam logic [15:0] XM = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        data_valid;
  logic [15:0] data;
  logic [15:0] crc_out;
  logic        crc_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Tap sets S0..S15 as bit-index lists, each terminated by -1.
  int tap_list [$] = '{
    0,2,3,6,7,8,9,10,13,-1,
    0,1,2,4,6,11,13,14,-1,
    1,2,3,5,7,12,14,15,-1,
    0,4,7,9,10,15,-1,
    0,1,2,3,5,6,7,9,11,13,-1,
    1,2,3,4,6,7,8,10,12,14,-1,
    0,4,5,6,10,11,15,-1,
    1,5,6,7,11,12,-1,
    0,3,9,10,12,-1,
    1,4,10,11,13,-1,
    0,3,5,6,7,8,9,10,11,12,13,14,-1,
    1,4,6,7,8,9,10,11,12,13,14,15,-1,
    0,3,5,6,11,12,14,15,-1,
    0,1,2,3,4,8,9,10,12,15,-1,
    0,1,4,5,6,7,8,11,-1,
    1,2,5,6,7,8,9,12,-1
  };

  // col[j] is the next state produced by a lone T bit j.
  logic [15:0] col [16];
  logic [15:0] model_state;
  logic        model_valid;

  crc16_word_engine #(
    .INIT   (INIT),
    .XOROUT (XOROUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .data_valid (data_valid),
    .data       (data),
    .crc_out    (crc_out),
    .crc_valid  (crc_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  task automatic build_columns();
    int row;
    row = 0;
    for (int j = 0; j < 16; j++) col[j] = 16'h0000;
    foreach (tap_list[k]) begin
      if (tap_list[k] < 0) row++;
      else col[tap_list[k]][row] = 1'b1;
    end
  endtask

  function automatic logic [15:0] ref_next(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] t;
    logic [15:0] r;
    t = s ^ d;
    r = 16'h0000;
    for (int j = 0; j < 16; j++) if (t[j]) r ^= col[j];
    return r;
  endfunction

  // Apply one cycle of inputs, advance the model, and compare just after the edge.
  task automatic cycle(input string tag, input logic clr, input logic vld, input logic [15:0] d);
    clear      = clr;
    data_valid = vld;
    data       = d;
    @(posedge clk);
    #1;
    if (clr) begin
      model_state = INIT;
      model_valid = 1'b0;
    end else if (vld) begin
      model_state = ref_next(model_state, d);
      model_valid = 1'b1;
    end else begin
      model_valid = 1'b0;
    end
    check({tag, "_crc"}, crc_out, model_state ^ XM);
    check({tag, "_vld"}, {15'd0, crc_valid}, {15'd0, model_valid});
  endtask

  initial begin
    build_columns();
    model_state = INIT;
    model_valid = 1'b0;
    rst_n      = 1'b0;
    clear      = 1'b0;
    data_valid = 1'b0;
    data       = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_crc", crc_out, INIT ^ XM);
    check("reset_vld", {15'd0, crc_valid}, 16'd0);
    rst_n = 1'b1;

    cycle("w0001", 1'b0, 1'b1, 16'h0001);
    check("dir_0001", crc_out, 16'h755B ^ XM);
    cycle("chain", 1'b0, 1'b1, 16'h755B);
    check("dir_chain", crc_out, 16'h0000 ^ XM);
    check("dir_chain_vld", {15'd0, crc_valid}, 16'd1);
    cycle("idle", 1'b0, 1'b0, 16'h0000);
    check("dir_idle_vld", {15'd0, crc_valid}, 16'd0);

    cycle("clr0", 1'b1, 1'b0, 16'h0000);
    cycle("w8000", 1'b0, 1'b1, 16'h8000);
    check("dir_8000", crc_out, 16'h384C ^ XM);
    cycle("clr1", 1'b1, 1'b0, 16'h0000);
    cycle("w8001", 1'b0, 1'b1, 16'h8001);
    check("dir_8001", crc_out, 16'h4D17 ^ XM);

    cycle("clr_and_valid", 1'b1, 1'b1, 16'h0001);
    check("dir_clr_win", crc_out, INIT ^ XM);
    check("dir_clr_vld", {15'd0, crc_valid}, 16'd0);

    cycle("pre_x", 1'b0, 1'b1, 16'h1234);
    cycle("x_hold", 1'b0, 1'b0, 16'hxxxx);

    // Asynchronous reset between edges, then the first word must fold from INIT.
    cycle("pre_rst", 1'b0, 1'b1, 16'hBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    model_state = INIT;
    model_valid = 1'b0;
    check("async_rst_crc", crc_out, INIT ^ XM);
    check("async_rst_vld", {15'd0, crc_valid}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("post_rst", 1'b0, 1'b1, 16'h0001);
    check("dir_post_rst", crc_out, 16'h755B ^ XM);

    for (int n = 0; n < 400; n++) begin
      logic        clr;
      logic        vld;
      logic [15:0] d;
      clr = ($urandom_range(15) == 0);
      vld = ($urandom_range(3) != 0);
      d   = 16'($urandom);
      cycle("rand", clr, vld, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
